// File: rtl/arb_rr2.sv
// arb_rr2 -- two-requester round-robin arbiter driving the select line of the
// downstream 2:1 mux (sel=0 -> source A, sel=1 -> source B).
// Each grant is held for at least HOLD cycles; ties from IDLE go to the side
// that was not served last. Handover between sources happens on one edge with
// no IDLE bubble, and sel keeps its value while idle so the mux never glitches.
//
// Optional feature: define ARB_TIMEOUT_EN to force a grant over to a waiting
// source once the current owner has held it for MAXG cycles. Without the macro
// a source keeps the grant for as long as it holds its request, and MAXG only
// takes part in the parameter range check.
module arb_rr2 #(
    parameter int HOLD = 4,   // minimum grant length in cycles, 1..2^CW
    parameter int CW   = 3,   // grant-age counter width
    parameter int MAXG = 8    // forced-release length, HOLD..2^CW
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic sel,
    output logic gnt_a,
    output logic gnt_b,
    output logic busy
);

    // Reject parameter sets the counter cannot represent.
    if (HOLD < 1 || HOLD > (1 << CW)) begin : g_bad_hold
        $error("arb_rr2: HOLD must lie in 1..2^CW");
    end
    if (MAXG < HOLD || MAXG > (1 << CW)) begin : g_bad_maxg
        $error("arb_rr2: MAXG must lie in HOLD..2^CW");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;       // cycles spent in the current grant, minus one
    logic          last_b;    // 1 when B was the most recently granted source
    logic          hold_ok;
    logic          entering;

    assign hold_ok  = (cnt >= HOLD_M1);
    assign entering = (state_nxt != IDLE) && (state_nxt != state);

`ifdef ARB_TIMEOUT_EN
    localparam logic [CW-1:0] MAXG_M1 = CW'(MAXG - 1);
    logic max_hit;
    assign max_hit = (cnt >= MAXG_M1);
`endif

    // Next-state selection: tie-break from IDLE, release or handover from a grant.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_a && (!req_b || last_b)) begin
                    state_nxt = GNT_A;
                end else if (req_b) begin
                    state_nxt = GNT_B;
                end
            end
            GNT_A: begin
                if (!req_a && hold_ok) begin
                    state_nxt = req_b ? GNT_B : IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (req_b && max_hit) begin
                    state_nxt = GNT_B;
                end
`endif
            end
            GNT_B: begin
                if (!req_b && hold_ok) begin
                    state_nxt = req_a ? GNT_A : IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (req_a && max_hit) begin
                    state_nxt = GNT_A;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, grant-age counter, round-robin history and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            last_b <= 1'b1;
            sel    <= 1'b0;
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt_a <= (state_nxt == GNT_A);
            gnt_b <= (state_nxt == GNT_B);
            busy  <= (state_nxt != IDLE);

            if (entering || state_nxt == IDLE) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            // sel and last only move when a new grant starts; idle keeps sel.
            if (entering) begin
                sel    <= (state_nxt == GNT_B);
                last_b <= (state_nxt == GNT_B);
            end
        end
    end

endmodule

// File: tb/tb_arb_rr2.sv
// tb_arb_rr2 -- self-checking bench for arb_rr2 with default parameters.
// A behavioural model tracks owner / cycles-held / last-served as plain
// integers and is stepped once per rising edge with the request values the
// DUT sampled. Directed scenarios are followed by randomized traffic with
// occasional asynchronous resets.
module tb_arb_rr2;

    localparam int HOLD = 4;
    localparam int CW   = 3;
    localparam int MAXG = 8;

    logic clk = 1'b0;
    logic rst;
    logic req_a;
    logic req_b;
    logic sel;
    logic gnt_a;
    logic gnt_b;
    logic busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 = nobody, 1 = A, 2 = B.
    int m_owner;
    int m_held;     // cycles the current owner has held the grant
    int m_last;     // last source served (1 = A, 2 = B)
    bit m_sel;

    arb_rr2 #(.HOLD(HOLD), .CW(CW), .MAXG(MAXG)) dut (
        .clk   (clk),
        .rst   (rst),
        .req_a (req_a),
        .req_b (req_b),
        .sel   (sel),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_held  = 0;
        m_last  = 2;
        m_sel   = 1'b0;
    endtask

    task automatic model_grant(input int who);
        m_owner = who;
        m_held  = 1;
        m_last  = who;
        m_sel   = (who == 2);
    endtask

    // One rising edge of the arbitration rules, from the sampled requests.
    task automatic model_step(input bit ra, input bit rb);
        bit mine;
        bit other;
        if (m_owner == 0) begin
            if (ra && rb)  model_grant(m_last == 1 ? 2 : 1);
            else if (ra)   model_grant(1);
            else if (rb)   model_grant(2);
        end else begin
            mine  = (m_owner == 1) ? ra : rb;
            other = (m_owner == 1) ? rb : ra;
            if (!mine && m_held >= HOLD) begin
                if (other) model_grant(3 - m_owner);
                else       m_owner = 0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (other && m_held >= MAXG) begin
                model_grant(3 - m_owner);
            end
`endif
            else begin
                m_held++;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".sel"},   int'(sel),   int'(m_sel));
        check({tag, ".gnt_a"}, int'(gnt_a), int'(m_owner == 1));
        check({tag, ".gnt_b"}, int'(gnt_b), int'(m_owner == 2));
        check({tag, ".busy"},  int'(busy),  int'(m_owner != 0));
    endtask

    // Called at a falling edge: drive requests, step model at the rising
    // edge, compare 1 time unit later, return at the next falling edge.
    task automatic cycle(input bit ra, input bit rb);
        req_a = ra;
        req_b = rb;
        @(posedge clk);
        model_step(ra, rb);
        #1;
        check_outputs("cyc");
        @(negedge clk);
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear at once.
    task automatic async_reset(input string tag);
        req_a = 1'b0;
        req_b = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check({tag, ".sel"},   int'(sel),   0);
        check({tag, ".gnt_a"}, int'(gnt_a), 0);
        check({tag, ".gnt_b"}, int'(gnt_b), 0);
        check({tag, ".busy"},  int'(busy),  0);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int cnt_a;
        int first;
        int pa;
        int winner;
        bit ra;
        bit rb;

        rst   = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;

        // Single one-cycle request: grant lasts exactly HOLD cycles, sel stays 0.
        cycle(1'b1, 1'b0);
        cnt_a = int'(gnt_a);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0);
            cnt_a += int'(gnt_a);
        end
        check("hold_len", cnt_a, HOLD);
        check("hold_idle_sel", int'(sel), 0);

        // Tie right after reset: A wins, then direct handover to B.
        async_reset("rst_tie");
        cycle(1'b1, 1'b1);
        check("tie_first_a", int'(gnt_a), 1);
        first = -1;
        for (int i = 0; i < 8; i++) begin
            pa = int'(gnt_a);
            cycle(1'b0, 1'b1);
            if (gnt_b && first < 0) begin
                first = i;
                check("handover_prev_a", pa, 1);
                check("handover_now_a", int'(gnt_a), 0);
                check("handover_sel", int'(sel), 1);
            end
        end
        check("handover_cycle", first, HOLD - 1);

        // Sticky sel: B releases to IDLE, sel remains 1.
        for (int i = 0; i < HOLD + 2; i++) cycle(1'b0, 1'b0);
        check("sticky_busy", int'(busy), 0);
        check("sticky_gnt_b", int'(gnt_b), 0);
        check("sticky_sel", int'(sel), 1);

        // Alternation: B was served last, so pulsed ties go A, B, A, B, ...
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'b1);
            winner = gnt_a ? 1 : (gnt_b ? 2 : 0);
            check("alternate", winner, (k % 2 == 0) ? 1 : 2);
            for (int i = 0; i < HOLD; i++) cycle(1'b0, 1'b0);
        end

        // Reset while B holds the grant with sel=1.
        cycle(1'b0, 1'b1);
        check("pre_rst_gnt_b", int'(gnt_b), 1);
        check("pre_rst_sel", int'(sel), 1);
        async_reset("rst_mid_grant");

        // A holds its request; B joins at grant cycle 2.
        cycle(1'b1, 1'b0);
        first = -1;
        cnt_a = 0;
        for (int i = 0; i < 55; i++) begin
            cycle(1'b1, i >= 1);
            if (gnt_b && first < 0) first = i;
            cnt_a += int'(gnt_a);
        end
`ifdef ARB_TIMEOUT_EN
        check("timeout_handover", first, MAXG - 1);
`else
        check("no_timeout_first_b", first, -1);
        check("no_timeout_a_cycles", cnt_a, 55);
`endif
        async_reset("rst_pre_random");

        // Random traffic: sticky requests, occasional async reset.
        ra = 1'b0;
        rb = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) ra = ~ra;
            if ($urandom_range(0, 3) == 0) rb = ~rb;
            if ($urandom_range(0, 99) == 0) begin
                async_reset("rst_rand");
                ra = 1'b0;
                rb = 1'b0;
            end else begin
                cycle(ra, rb);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
